// File: rtl/dmem_responder_if.sv
// Request/response bus between the datapath (master) and the data memory
// responder (slave): one request channel, one response channel, each with
// its own valid/ready handshake.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with a fixed-latency valid/ready response.
// One request is outstanding at a time: IDLE accepts, WAIT counts down the
// configured latency, RESP presents the captured result until it is taken.
// Memory is written/read at the acceptance edge; the response is only
// delayed, so a reset after acceptance drops the response but keeps writes.
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    localparam int         AW    = $clog2(DEPTH);
    localparam logic [3:0] LAT_C = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [3:0]      cnt_r;
    logic [3:0]      cnt_nxt_s;
    logic            req_ready_r;
    logic            rsp_valid_r;
    logic            rsp_err_r;
    logic [31:0]     rsp_rdata_r;
    logic            hold_err_r;
    logic [31:0]     hold_rdata_r;
    logic            accept_s;
    logic            err_s;
    logic            wr_en_s;
    logic [AW-1:0]   idx_s;
    logic [31:0]     mem_r [DEPTH];

    // Request decode: handshake, address legality and word index
    always_comb begin
        accept_s = bus.req_valid && req_ready_r && !reset;
        err_s    = (bus.req_addr[1:0] != 2'b00) ||
                   (bus.req_addr[31:2] >= 30'(DEPTH));
        idx_s    = bus.req_addr[AW+1:2];
        wr_en_s  = accept_s && bus.req_we && !err_s;
    end

    // Next-state logic: accept in IDLE, count latency in WAIT, hold in RESP
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_nxt_s   = LAT_C;
                    state_nxt_s = (LATENCY == 0) ? ST_RESP : ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_nxt_s = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // State, counter and handshake flags, registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            req_ready_r <= (state_nxt_s == ST_IDLE);
            rsp_valid_r <= (state_nxt_s == ST_RESP);
        end
    end

    // Word storage: single write port and no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[idx_s] <= bus.req_wdata;
        end
    end

    // Response capture at acceptance; data/err are only driven while in RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_err_r   <= 1'b0;
            hold_rdata_r <= 32'h0000_0000;
            rsp_err_r    <= 1'b0;
            rsp_rdata_r  <= 32'h0000_0000;
        end else begin
            if (accept_s) begin
                hold_err_r   <= err_s;
                hold_rdata_r <= (err_s || bus.req_we) ? 32'h0000_0000 : mem_r[idx_s];
            end
            if (state_nxt_s == ST_RESP) begin
                if (accept_s) begin
                    rsp_err_r   <= err_s;
                    rsp_rdata_r <= (err_s || bus.req_we) ? 32'h0000_0000 : mem_r[idx_s];
                end else begin
                    rsp_err_r   <= hold_err_r;
                    rsp_rdata_r <= hold_rdata_r;
                end
            end else begin
                rsp_err_r   <= 1'b0;
                rsp_rdata_r <= 32'h0000_0000;
            end
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: dut0 (DEPTH=64, LATENCY=2) is followed every
// cycle by a timestamp-based reference model; dut1 (LATENCY=0) is exercised
// for back-to-back throughput. Directed transactions pin literal values.
module tb_dmem_responder;
    localparam int DEPTH0 = 64;
    localparam int LAT0   = 2;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic chk_en = 1'b0;

    dmem_responder_if b0 ();
    dmem_responder_if b1 ();

    dmem_responder #(.DEPTH(DEPTH0), .LATENCY(LAT0)) dut0 (
        .clk(clk), .reset(reset), .bus(b0.slave));
    dmem_responder #(.DEPTH(DEPTH0), .LATENCY(0)) dut1 (
        .clk(clk), .reset(reset), .bus(b1.slave));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [31:0] a);
        return ((a % 32'd4) == 32'd0) && (a < 32'(DEPTH0 * 4));
    endfunction

    // Reference model: a request accepted while the block is free at cycle n
    // becomes visible from cycle n+LAT0+1 and stays until taken.
    int          cyc    = 0;
    int          m_due  = 0;
    logic        m_busy = 1'b0;
    logic        m_err  = 1'b0;
    logic [31:0] m_data = 32'h0;
    logic [31:0] m_mem [DEPTH0];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_busy <= 1'b0;
        end else if (!m_busy) begin
            if (b0.req_valid) begin
                m_busy <= 1'b1;
                m_due  <= cyc + LAT0 + 1;
                m_err  <= !legal(b0.req_addr);
                if (legal(b0.req_addr) && b0.req_we)
                    m_mem[b0.req_addr / 32'd4] <= b0.req_wdata;
                if (legal(b0.req_addr) && !b0.req_we)
                    m_data <= m_mem[b0.req_addr / 32'd4];
                else
                    m_data <= 32'h0;
            end
        end else if (cyc >= m_due && b0.rsp_ready) begin
            m_busy <= 1'b0;
        end
    end

    // Compare dut0 outputs with the model away from the clock edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", b0.req_ready, !m_busy);
            check("rsp_valid", b0.rsp_valid, m_busy && (cyc >= m_due));
            check("rsp_rdata", b0.rsp_rdata, (m_busy && (cyc >= m_due)) ? m_data : 32'h0);
            check("rsp_err",   b0.rsp_err,   m_busy && (cyc >= m_due) && m_err);
        end
    end

    // One dut0 transaction; call at #1 after a posedge while dut0 is idle.
    task automatic txn0(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        b0.req_valid = 1'b1;
        b0.req_we    = we;
        b0.req_addr  = addr;
        b0.req_wdata = wd;
        b0.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        b0.req_valid = 1'b0;
        lat = 0;
        rd  = 32'h0;
        er  = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (b0.rsp_valid) begin
                lat = k;
                rd  = b0.rsp_rdata;
                er  = b0.rsp_err;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        seen;
    int          acc;
    int          pend;
    logic        rdy;
    int          sel;
    logic [31:0] idx;

    initial begin
        reset = 1'b1;
        b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = 32'h0; b0.req_wdata = 32'h0;
        b0.rsp_ready = 1'b0;
        b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = 32'h0; b1.req_wdata = 32'h0;
        b1.rsp_ready = 1'b1;
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_ready", b0.req_ready, 1'b1);
        check("reset_valid", b0.rsp_valid, 1'b0);
        check("reset_rdata", b0.rsp_rdata, 32'h0);
        check("reset_err",   b0.rsp_err,   1'b0);
        @(posedge clk);
        #1;

        // Write then read back with latency measurement
        txn0(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check("wr10_lat", 32'(lat), 32'd3);
        check("wr10_rd", rd, 32'h0);
        check("wr10_err", er, 1'b0);
        txn0(1'b0, 32'h10, 32'h0, rd, er, lat);
        check("rd10_lat", 32'(lat), 32'd3);
        check("rd10_rd", rd, 32'hDEADBEEF);
        check("rd10_err", er, 1'b0);

        // Error requests leave memory untouched
        txn0(1'b1, 32'h0, 32'hA5A50000, rd, er, lat);
        txn0(1'b1, 32'h30, 32'h0BADF00D, rd, er, lat);
        txn0(1'b0, 32'h13, 32'h0, rd, er, lat);
        check("mis_err", er, 1'b1);
        check("mis_rd", rd, 32'h0);
        txn0(1'b0, 32'h100, 32'h0, rd, er, lat);
        check("oor_err", er, 1'b1);
        check("oor_rd", rd, 32'h0);
        txn0(1'b1, 32'h100, 32'hFFFFFFFF, rd, er, lat);
        check("oorw_err", er, 1'b1);
        txn0(1'b0, 32'h0, 32'h0, rd, er, lat);
        check("alias_rd", rd, 32'hA5A50000);
        check("alias_err", er, 1'b0);

        // Response held with rsp_ready low while a new request is offered
        b0.rsp_ready = 1'b0;
        b0.req_we = 1'b0; b0.req_addr = 32'h10; b0.req_valid = 1'b1;
        @(posedge clk);
        #1;
        b0.req_we = 1'b1; b0.req_addr = 32'h30; b0.req_wdata = 32'hBAD0BAD0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = b0.rsp_valid;
        end
        check("hold_reached", seen, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", b0.rsp_valid, 1'b1);
            check("hold_rdata", b0.rsp_rdata, 32'hDEADBEEF);
            check("hold_ready", b0.req_ready, 1'b0);
            @(negedge clk);
        end
        b0.req_valid = 1'b0;
        b0.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        txn0(1'b0, 32'h30, 32'h0, rd, er, lat);
        check("ignored_wr", rd, 32'h0BADF00D);

        // Reset while waiting: response dropped, write persists
        b0.req_we = 1'b1; b0.req_addr = 32'h20; b0.req_wdata = 32'h12345678; b0.req_valid = 1'b1;
        @(posedge clk);
        #1 b0.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", b0.req_ready, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (b0.rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("rst_no_rsp", seen, 1'b0);
        @(posedge clk);
        #1;
        txn0(1'b0, 32'h20, 32'h0, rd, er, lat);
        check("rst_wr_kept", rd, 32'h12345678);

        // Back-to-back writes to the last word
        txn0(1'b1, 32'(DEPTH0 - 1) * 32'd4, 32'hAAAA0001, rd, er, lat);
        check("last_w1_err", er, 1'b0);
        txn0(1'b1, 32'(DEPTH0 - 1) * 32'd4, 32'h55550002, rd, er, lat);
        txn0(1'b0, 32'(DEPTH0 - 1) * 32'd4, 32'h0, rd, er, lat);
        check("last_rd", rd, 32'h55550002);

        // Zero-latency throughput on dut1 with rsp_ready tied high
        for (int ph = 0; ph < 2; ph++) begin
            acc = 0;
            pend = 0;
            b1.req_valid = 1'b1;
            b1.req_we = (ph == 0);
            for (int c = 0; c < 16; c++) begin
                b1.req_addr  = 32'(acc % 8) * 32'd4;
                b1.req_wdata = 32'hC0DE0000 + 32'(acc);
                @(negedge clk);
                rdy = b1.req_ready;
                check("l0_alternate", b1.rsp_valid, !rdy);
                if (ph == 1 && b1.rsp_valid)
                    check("l0_rdata", b1.rsp_rdata, 32'hC0DE0000 + 32'(pend));
                @(posedge clk);
                if (rdy) begin
                    pend = acc % 8;
                    acc++;
                end
                #1;
            end
            check("l0_accepts", 32'(acc), 32'd8);
        end
        b1.req_valid = 1'b0;

        // Fill dut0 with known data, then random traffic against the model
        for (int i = 0; i < DEPTH0; i++)
            txn0(1'b1, 32'(i) * 32'd4, $urandom, rd, er, lat);
        for (int c = 0; c < 3000; c++) begin
            b0.req_valid = ($urandom_range(0, 2) != 0);
            b0.req_we    = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            idx = 32'($urandom_range(0, DEPTH0 - 1));
            case (sel)
                0:       b0.req_addr = idx * 32'd4 + 32'($urandom_range(1, 3));
                1:       b0.req_addr = $urandom;
                2:       b0.req_addr = 32'h100 + idx * 32'd4;
                default: b0.req_addr = idx * 32'd4;
            endcase
            b0.req_wdata = $urandom;
            b0.rsp_ready = ($urandom_range(0, 3) != 0);
            reset        = ($urandom_range(0, 199) == 0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        b0.req_valid = 1'b0;
        b0.rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words of storage (a power of 2, 4..1024).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the number of wait cycles between request acceptance and response (0..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the datapath presents a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have port req_addr, input, 32 bits: byte address (datapath ALUResult).
REQ-009 The block SHALL have port req_wdata, input, 32 bits: write data (datapath WriteData).
REQ-010 The block SHALL have port rsp_valid, output, 1 bit: a response is presented.
REQ-011 The block SHALL have port rsp_ready, input, 1 bit: the datapath takes the response.
REQ-012 The block SHALL have port rsp_rdata, output, 32 bits: read data (datapath ReadData).
REQ-013 The block SHALL have port rsp_err, output, 1 bit: the request was misaligned or out of range.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, WAIT and RESP, with at most one request outstanding.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted at the edge where req_valid and req_ready are both 1.
REQ-016 On acceptance, the block SHALL flag an error if req_addr[1:0] != 0 or req_addr[31:2] >= DEPTH; the word index SHALL be req_addr[log2(DEPTH)+1:2].
REQ-017 On acceptance of a legal write, mem[index] SHALL be written with req_wdata at that same edge, and the captured rdata SHALL be 0.
REQ-018 On acceptance of a legal read, the block SHALL capture mem[index] at that edge into the response register.
REQ-019 On acceptance of an errored request, the block SHALL leave memory unchanged, capture rdata = 0 and err = 1.
REQ-020 On acceptance, the FSM SHALL go to WAIT with the counter loaded to LATENCY; when LATENCY = 0 it SHALL go directly to RESP.
REQ-021 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL move to RESP on the edge where the counter equals 1.
REQ-022 rsp_valid SHALL therefore first be 1 exactly LATENCY+1 cycles after the acceptance edge.
REQ-023 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_err SHALL be held stable until the edge where rsp_ready = 1; the FSM SHALL then return to IDLE.
REQ-024 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid = 0.
REQ-025 req_valid in WAIT or RESP SHALL be ignored, with no side effect.
REQ-026 rsp_ready while rsp_valid = 0 SHALL be ignored.
REQ-027 A new request SHALL be accepted no earlier than the cycle after the response handshake, giving a minimum period of LATENCY+2 cycles.
REQ-028 Storage SHALL be word-only (no byte or halfword lanes) and SHALL be inferable as synchronous RAM.

Reset
REQ-029 While reset = 1 at an edge, the FSM SHALL go to IDLE, the counter to 0, and rsp_valid, rsp_rdata and rsp_err to 0; req_ready SHALL be 1 in the cycle after reset deasserts.
REQ-030 Reset SHALL NOT clear memory contents.
REQ-031 Reset in WAIT or RESP SHALL drop the pending response; a write already committed at acceptance SHALL persist.
REQ-032 reset SHALL have priority over a simultaneous request or response handshake.

Verification
REQ-033 Write 0xDEADBEEF to 0x10, then read 0x10 with LATENCY = 2: rsp_valid rises 3 cycles after each acceptance; read returns rsp_rdata = 0xDEADBEEF, rsp_err = 0.
REQ-034 Read 0x13 (misaligned) and read 0x100 with DEPTH = 64: rsp_err = 1, rsp_rdata = 0; a following read of index 0x40 wrap-alias shows no corruption.
REQ-035 Hold rsp_ready = 0 for 5 cycles in RESP: rsp_valid and rsp_rdata stay stable, req_ready = 0, and a concurrent req_valid is ignored.
REQ-036 With LATENCY = 0 and rsp_ready tied to 1: one request is accepted every 2 cycles, with rsp_valid 1 cycle after acceptance.
REQ-037 Assert reset during WAIT after writing 0x12345678 to 0x20: no response appears, req_ready = 1 after reset, and a subsequent read of 0x20 returns 0x12345678.
REQ-038 Issue back-to-back writes to the last word (address (DEPTH-1)*4), then read it: the read returns the second write's data.
